// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, status flags and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_CMP  = 3'd2,
    ALU_ROTL = 3'd3,
    ALU_ROTR = 3'd4,
    ALU_AND  = 3'd5,
    ALU_OR   = 3'd6,
    ALU_XOR  = 3'd7
  } op_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ROT  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor shared by ADD, SUB and CMP.
module alu_addsub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH:0] ext;

  always_comb begin
    // The extra bit is the carry for add and the borrow (a < b) for subtract
    ext    = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    result = ext[WIDTH-1:0];
    carry  = ext[WIDTH];
    if (sub) begin
      ovf = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
    end else begin
      ovf = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
    end
  end

endmodule

// File: rtl/alu_seq_core.sv
// Registered ALU with valid/ready handshakes; rotates iterate one bit per cycle.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               rot_left_q, rot_left_d;
  logic [WIDTH-1:0]   res_q, res_d;
  flags_t             flags_q, flags_d;

  op_e                op;
  logic [SHAMT_W-1:0] amt;
  logic [WIDTH-1:0]   as_result;
  logic               as_carry;
  logic               as_ovf;
  logic [WIDTH-1:0]   rot_step;

  assign op  = op_e'(in_op);
  assign amt = in_b[SHAMT_W-1:0];

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a      (in_a),
    .b      (in_b),
    .sub    (op != ALU_ADD),
    .result (as_result),
    .carry  (as_carry),
    .ovf    (as_ovf)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    rot_left_d = rot_left_q;
    res_d      = res_q;
    flags_d    = flags_q;
    rot_step   = rot_left_q ? {acc_q[WIDTH-2:0], acc_q[WIDTH-1]}
                            : {acc_q[0], acc_q[WIDTH-1:1]};

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_DONE;
          flags_d = '0;
          case (op)
            ALU_ADD, ALU_SUB: begin
              res_d         = as_result;
              flags_d.carry = as_carry;
              flags_d.ovf   = as_ovf;
            end
            ALU_CMP: begin
              res_d         = '0;
              res_d[0]      = as_carry;
              flags_d.carry = as_carry;
            end
            ALU_AND: res_d = in_a & in_b;
            ALU_OR:  res_d = in_a | in_b;
            ALU_XOR: res_d = in_a ^ in_b;
            default: begin
              // Rotates: zero amount completes immediately, otherwise iterate
              if (amt == '0) begin
                res_d = in_a;
              end else begin
                acc_d      = in_a;
                cnt_d      = amt;
                rot_left_d = (op == ALU_ROTL);
                state_d    = ST_ROT;
                res_d      = res_q;
                flags_d    = flags_q;
              end
            end
          endcase
          if (state_d == ST_DONE) begin
            flags_d.zero = (op == ALU_CMP) ? (in_a == in_b) : (res_d == '0);
            flags_d.neg  = (op == ALU_CMP) ? 1'b0 : res_d[WIDTH-1];
          end
        end
      end
      ST_ROT: begin
        acc_d = rot_step;
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          res_d         = rot_step;
          flags_d       = '0;
          flags_d.zero  = (rot_step == '0);
          flags_d.neg   = rot_step[WIDTH-1];
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      rot_left_q <= 1'b0;
      res_q      <= '0;
      flags_q    <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      rot_left_q <= rot_left_d;
      res_q      <= res_d;
      flags_q    <= flags_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = res_q;
  assign out_carry  = flags_q.carry;
  assign out_zero   = flags_q.zero;
  assign out_neg    = flags_q.neg;
  assign out_ovf    = flags_q.ovf;

endmodule
